// File: rtl/thread_dispatcher_pkg.sv
// thread_dispatcher_pkg
//   Shared types and sizing for the 4-thread / 3-ALU issue scheduler.
//   Imported by thread_dispatcher and thread_dispatcher_rr_slot_picker.
//   Contents:
//     NUM_Threads, NUM_ALUs          core geometry
//     FLUSH_CYCLES, STARTUP_CYCLES   bubble / warm-up lengths
//     tid_t, IDLE_TID                3-bit slot thread id, 3'd4 = nothing issued
//     flush_cnt_t, thr_idx_t         2-bit per-thread counter and thread index
//     next_thread()                  round-robin successor of a thread index

package thread_dispatcher_pkg;

  localparam int NUM_Threads    = 4;
  localparam int NUM_ALUs       = 3;
  localparam int FLUSH_CYCLES   = 2;
  localparam int STARTUP_CYCLES = 2;

  typedef logic [2:0] tid_t;
  typedef logic [1:0] flush_cnt_t;
  typedef logic [1:0] thr_idx_t;

  // Thread ids 0..3 are real threads, so 4 is free to mean "slot unused".
  localparam tid_t IDLE_TID = 3'd4;

  // Successor modulo NUM_Threads (explicit wrap so NUM_Threads < 4 also works).
  function automatic thr_idx_t next_thread(input thr_idx_t idx);
    thr_idx_t nxt;
    if (idx == thr_idx_t'(NUM_Threads - 1)) nxt = '0;
    else                                    nxt = idx + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/thread_dispatcher_rr_slot_picker.sv
// thread_dispatcher_rr_slot_picker
//   Purely combinational round-robin matcher between eligible threads and
//   ready ALU slots. Threads are scanned starting at i_rr_ptr; the k-th
//   eligible thread lands in the k-th ready slot. Each thread fills at most
//   one slot; unfilled or not-ready slots carry IDLE_TID.
//   Ports:
//     i_elig       [NUM_Threads]  thread may issue this cycle
//     i_alu_ready  [NUM_ALUs]     slot can accept an issue
//     i_rr_ptr                    first thread id in scan order
//     o_slot_tid   [NUM_ALUs]     thread chosen per slot (IDLE_TID if none)
//     o_last_tid                  thread placed in the highest filled slot
//     o_any_grant                 at least one slot was filled

module thread_dispatcher_rr_slot_picker
  import thread_dispatcher_pkg::*;
(
  input  logic [NUM_Threads-1:0] i_elig,
  input  logic [NUM_ALUs-1:0]    i_alu_ready,
  input  thr_idx_t               i_rr_ptr,
  output tid_t [NUM_ALUs-1:0]    o_slot_tid,
  output thr_idx_t               o_last_tid,
  output logic                   o_any_grant
);

  logic [NUM_Threads-1:0] w_taken;
  logic                   w_found;
  thr_idx_t               w_idx;
  int                     w_sum;

  // Each ready slot takes the first not-yet-taken eligible thread in
  // rotated order; w_taken keeps a thread from landing in two slots.
  always_comb begin
    w_taken     = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    w_sum       = 0;
    o_last_tid  = '0;
    o_any_grant = 1'b0;
    for (int a = 0; a < NUM_ALUs; a++) begin
      o_slot_tid[a] = IDLE_TID;
    end
    for (int a = 0; a < NUM_ALUs; a++) begin
      w_found = 1'b0;
      if (i_alu_ready[a]) begin
        for (int j = 0; j < NUM_Threads; j++) begin
          w_sum = int'(i_rr_ptr) + j;
          if (w_sum >= NUM_Threads) w_sum = w_sum - NUM_Threads;
          w_idx = thr_idx_t'(w_sum);
          if (!w_found && i_elig[w_idx] && !w_taken[w_idx]) begin
            w_found        = 1'b1;
            w_taken[w_idx] = 1'b1;
            o_slot_tid[a]  = tid_t'(w_idx);
            o_last_tid     = w_idx;
            o_any_grant    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/thread_dispatcher.sv
// thread_dispatcher
//   Per-cycle issue scheduler for the 4-thread / 3-ALU core. Each cycle it
//   grants up to NUM_ALUs eligible threads in round-robin order and registers
//   one thread id per ALU slot (IDLE_TID when nothing is issued). Owns the
//   per-thread jump-flush bubbles and the post-reset warm-up window.
//   Optional build macro: DISPATCH_STATS_EN adds per-thread issue counters
//   and a saturating idle-slot counter.
//   Ports:
//     clk, rst                       clock, asynchronous active-high reset
//     i_inst_valid  [NUM_Threads]    decoded instruction available
//     i_hold        [NUM_Threads]    thread stalled
//     i_jump_en     [NUM_Threads]    thread redirecting this cycle
//     i_alu_ready   [NUM_ALUs]       ALU can accept an issue
//     o_dispatch_threads [NUM_ALUs]  thread id per slot, IDLE_TID = none
//     o_dispatch_valid   [NUM_ALUs]  slot carries a real thread
//     o_issue_count [NUM_Threads]    (DISPATCH_STATS_EN) grants per thread, wrapping
//     o_idle_slot_count              (DISPATCH_STATS_EN) idle slots, saturating

module thread_dispatcher
  import thread_dispatcher_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_Threads-1:0] i_inst_valid,
  input  logic [NUM_Threads-1:0] i_hold,
  input  logic [NUM_Threads-1:0] i_jump_en,
  input  logic [NUM_ALUs-1:0]    i_alu_ready,
  output tid_t [NUM_ALUs-1:0]    o_dispatch_threads,
  output logic [NUM_ALUs-1:0]    o_dispatch_valid
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_Threads-1:0][15:0] o_issue_count,
  output logic [15:0]                  o_idle_slot_count
`endif
);

  tid_t [NUM_ALUs-1:0]          r_dispatch_threads;
  logic [NUM_ALUs-1:0]          r_dispatch_valid;
  thr_idx_t                     r_rr_ptr;
  flush_cnt_t [NUM_Threads-1:0] r_flush_cnt;
  logic [1:0]                   r_startup_cnt;

  logic [NUM_Threads-1:0] w_elig;
  tid_t [NUM_ALUs-1:0]    w_slot_tid;
  thr_idx_t               w_last_tid;
  logic                   w_any_grant;
  logic                   w_startup;

  assign w_startup = (r_startup_cnt != 2'd0);

  // A thread redirecting this cycle is already excluded, before its flush
  // counter has even been loaded.
  always_comb begin
    for (int t = 0; t < NUM_Threads; t++) begin
      w_elig[t] = i_inst_valid[t] & ~i_hold[t] & ~i_jump_en[t] &
                  (r_flush_cnt[t] == '0);
    end
  end

  thread_dispatcher_rr_slot_picker u_picker (
    .i_elig      (w_elig),
    .i_alu_ready (i_alu_ready),
    .i_rr_ptr    (r_rr_ptr),
    .o_slot_tid  (w_slot_tid),
    .o_last_tid  (w_last_tid),
    .o_any_grant (w_any_grant)
  );

  // Outputs and rr pointer: frozen idle (pointer held) during warm-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dispatch_threads <= {NUM_ALUs{IDLE_TID}};
      r_dispatch_valid   <= '0;
      r_rr_ptr           <= '0;
      r_startup_cnt      <= 2'(STARTUP_CYCLES);
    end else if (w_startup) begin
      r_startup_cnt      <= r_startup_cnt - 2'd1;
      r_dispatch_threads <= {NUM_ALUs{IDLE_TID}};
      r_dispatch_valid   <= '0;
    end else begin
      r_dispatch_threads <= w_slot_tid;
      for (int a = 0; a < NUM_ALUs; a++) begin
        r_dispatch_valid[a] <= (w_slot_tid[a] != IDLE_TID);
      end
      if (w_any_grant) r_rr_ptr <= next_thread(w_last_tid);
    end
  end

  // Flush counters also run during warm-up; a new jump reloads the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else begin
      for (int t = 0; t < NUM_Threads; t++) begin
        if (i_jump_en[t])
          r_flush_cnt[t] <= flush_cnt_t'(FLUSH_CYCLES);
        else if (r_flush_cnt[t] != '0)
          r_flush_cnt[t] <= r_flush_cnt[t] - 2'd1;
      end
    end
  end

  assign o_dispatch_threads = r_dispatch_threads;
  assign o_dispatch_valid   = r_dispatch_valid;

`ifdef DISPATCH_STATS_EN
  localparam int CNT_W = $clog2(NUM_ALUs + 1);

  logic [NUM_Threads-1:0][15:0] r_issue_count;
  logic [15:0]                  r_idle_slot_count;
  logic [NUM_Threads-1:0]       w_granted;
  logic [CNT_W-1:0]             w_idle_slots;
  logic [16:0]                  w_idle_sum;

  // Stats track what is being registered onto the outputs this edge.
  always_comb begin
    w_granted    = '0;
    w_idle_slots = '0;
    for (int a = 0; a < NUM_ALUs; a++) begin
      if (w_slot_tid[a] == IDLE_TID) begin
        w_idle_slots = w_idle_slots + CNT_W'(1);
      end else begin
        w_granted[w_slot_tid[a][1:0]] = 1'b1;
      end
    end
    if (w_startup) begin
      w_granted    = '0;
      w_idle_slots = CNT_W'(NUM_ALUs);
    end
    w_idle_sum = {1'b0, r_idle_slot_count} + 17'(w_idle_slots);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_count     <= '0;
      r_idle_slot_count <= '0;
    end else begin
      for (int t = 0; t < NUM_Threads; t++) begin
        if (w_granted[t]) r_issue_count[t] <= r_issue_count[t] + 16'd1;
      end
      r_idle_slot_count <= w_idle_sum[16] ? 16'hFFFF : w_idle_sum[15:0];
    end
  end

  assign o_issue_count     = r_issue_count;
  assign o_idle_slot_count = r_idle_slot_count;
`endif

endmodule

// File: tb/tb_thread_dispatcher.sv
// tb_thread_dispatcher
//   Directed scoreboard bench for thread_dispatcher. Each step drives inputs,
//   pushes the hand-derived expected slot ids onto a queue, then pops and
//   compares one cycle later (#1 after the posedge). Build with
//   DISPATCH_STATS_EN defined to also check the statistics counters.

module tb_thread_dispatcher;
  import thread_dispatcher_pkg::*;

  localparam tid_t I = IDLE_TID;

  logic            clock;
  logic            reset;
  logic [3:0]      instValid;
  logic [3:0]      hold;
  logic [3:0]      jumpEn;
  logic [2:0]      aluReady;
  tid_t [2:0]      dispatchThreads;
  logic [2:0]      dispatchValid;
`ifdef DISPATCH_STATS_EN
  logic [3:0][15:0] issueCount;
  logic [15:0]      idleSlotCount;
`endif

  string      tagQ[$];
  logic [8:0] expThreadsQ[$];
  logic [2:0] expValidQ[$];
  int         checkCount = 0;
  int         errorCount = 0;
  int         obsIssue[4];

  thread_dispatcher dut (
    .clk                (clock),
    .rst                (reset),
    .i_inst_valid       (instValid),
    .i_hold             (hold),
    .i_jump_en          (jumpEn),
    .i_alu_ready        (aluReady),
    .o_dispatch_threads (dispatchThreads),
    .o_dispatch_valid   (dispatchValid)
`ifdef DISPATCH_STATS_EN
    ,
    .o_issue_count      (issueCount),
    .o_idle_slot_count  (idleSlotCount)
`endif
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive inputs and queue the slot ids expected after the next edge.
  task automatic applyStimulus(input string tag, input logic [3:0] iv,
                               input logic [3:0] h, input logic [3:0] j,
                               input logic [2:0] ar, input tid_t s0,
                               input tid_t s1, input tid_t s2);
    instValid = iv;
    hold      = h;
    jumpEn    = j;
    aluReady  = ar;
    tagQ.push_back(tag);
    expThreadsQ.push_back({s2, s1, s0});
    expValidQ.push_back({s2 != I, s1 != I, s0 != I});
  endtask

  // Optionally wait for the edge, then pop one expectation and compare.
  task automatic checkOutput(input logic waitEdge);
    string      tag;
    logic [8:0] expThreads;
    logic [2:0] expValid;
    if (waitEdge) begin
      @(posedge clock);
      #1;
    end
    if (tagQ.size() == 0) begin
      checkCount++;
      errorCount++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      tag        = tagQ.pop_front();
      expThreads = expThreadsQ.pop_front();
      expValid   = expValidQ.pop_front();
      checkCount++;
      assert (dispatchThreads === expThreads) else begin
        errorCount++;
        $error("[TB] FAIL %s threads observed=%h expected=%h", tag,
               dispatchThreads, expThreads);
      end
      checkCount++;
      assert (dispatchValid === expValid) else begin
        errorCount++;
        $error("[TB] FAIL %s valid observed=%b expected=%b", tag,
               dispatchValid, expValid);
      end
    end
  endtask

  task automatic step(input string tag, input logic [3:0] iv,
                      input logic [3:0] h, input logic [3:0] j,
                      input logic [2:0] ar, input tid_t s0,
                      input tid_t s1, input tid_t s2);
    applyStimulus(tag, iv, h, j, ar, s0, s1, s2);
    checkOutput(1'b1);
  endtask

  task automatic checkValue(input string tag, input int observed,
                            input int expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed,
             expected);
    end
  endtask

  task automatic tallyIssues();
    for (int a = 0; a < 3; a++) begin
      if (dispatchThreads[a] != I) obsIssue[dispatchThreads[a][1:0]]++;
    end
  endtask

  initial begin
    $display("[TB] thread_dispatcher bench starting");
    for (int t = 0; t < 4; t++) obsIssue[t] = 0;

    // Reset state, checked before any clock edge.
    reset = 1'b1;
    applyStimulus("reset", 4'b1111, 4'b0000, 4'b0000, 3'b111, I, I, I);
    #1;
    checkOutput(1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Warm-up window, then steady rotation with everyone eligible.
    step("startup1", 4'b1111, 4'b0000, 4'b0000, 3'b111, I, I, I);
    step("startup2", 4'b1111, 4'b0000, 4'b0000, 3'b111, I, I, I);
    step("rot1", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd0, 3'd1, 3'd2);
    tallyIssues();
    step("rot2", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd3, 3'd0, 3'd1);
    tallyIssues();
    step("rot3", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd2, 3'd3, 3'd0);
    tallyIssues();
    step("rot4", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd1, 3'd2, 3'd3);
    tallyIssues();
    for (int t = 0; t < 4; t++) begin
      checkValue($sformatf("rot_issues_t%0d", t), obsIssue[t], 3);
    end
    step("rot5", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd0, 3'd1, 3'd2);
    step("rot6", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd3, 3'd0, 3'd1);
    step("rot7", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd2, 3'd3, 3'd0);
    step("rot8", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd1, 3'd2, 3'd3);
`ifdef DISPATCH_STATS_EN
    for (int t = 0; t < 4; t++) begin
      checkValue($sformatf("issue_count_t%0d", t), int'(issueCount[t]), 6);
    end
    checkValue("idle_slot_count", int'(idleSlotCount), 6);
`endif

    // Jump on thread 1: absent this cycle and the next two.
    step("jump0", 4'b1111, 4'b0000, 4'b0010, 3'b111, 3'd0, 3'd2, 3'd3);
    step("jump1", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd0, 3'd2, 3'd3);
    step("jump2", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd0, 3'd2, 3'd3);
    step("jump3", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd0, 3'd1, 3'd2);

    // Hold plus ALU gating, all-hold, then pointer must not have moved.
    step("gate", 4'b1111, 4'b0101, 4'b0000, 3'b101, 3'd3, I, 3'd1);
    step("allhold", 4'b1111, 4'b1111, 4'b0000, 3'b111, I, I, I);
    step("afterhold", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd2, 3'd3, 3'd0);
    step("nocalu", 4'b1111, 4'b0000, 4'b0000, 3'b000, I, I, I);
    step("afteralu", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd1, 3'd2, 3'd3);
    step("single", 4'b0100, 4'b0000, 4'b0000, 3'b111, 3'd2, I, I);
    step("slot0off", 4'b1111, 4'b0000, 4'b0000, 3'b110, I, 3'd3, 3'd0);
    step("resume", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd1, 3'd2, 3'd3);

    // Asynchronous reset between edges, then the warm-up repeats.
    #1;
    reset = 1'b1;
    #1;
    applyStimulus("async_rst", 4'b1111, 4'b0000, 4'b0000, 3'b111, I, I, I);
    checkOutput(1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("restart1", 4'b1111, 4'b0000, 4'b0000, 3'b111, I, I, I);
    step("restart2", 4'b1111, 4'b0000, 4'b0000, 3'b111, I, I, I);
    step("restart3", 4'b1111, 4'b0000, 4'b0000, 3'b111, 3'd0, 3'd1, 3'd2);
`ifdef DISPATCH_STATS_EN
    checkValue("idle_after_rst", int'(idleSlotCount), 6);
`endif

    checkValue("scoreboard_drained", tagQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
